fb_write_scheduler: RTL and testbench
=====================================

# fb_write_scheduler

Write-port controller for the pixel frame-buffer `Memory`. It owns the memory's single write port and shares it between two requesters:
- single-pixel writes from the ASIP core;
- an internal rectangle-fill sequencer that rasters a solid-colour rectangle, used for clear screen and box draw.

Core writes have priority. The fill stalls for any cycle the core writes. All outputs to the memory are registered.

## Interface
- Width, 320, frame width in pixels (≤ 512)
- Height, 240, frame height in pixels (≤ 256)
- ColorBits, 3, bits per pixel
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- PxValid  in  1  core pixel write request
- PxReady  out  1  core request accepted; equals !rst
- PxX  in  9  core pixel column
- PxY  in  8  core pixel row
- PxColor  in  ColorBits  core pixel value
- FillStart  in  1  start rectangle fill; sampled only in IDLE
- FillX0, FillX1  in  9  inclusive column bounds
- FillY0, FillY1  in  8  inclusive row bounds
- FillColor  in  ColorBits  fill value
- FillBusy  out  1  state != IDLE
- FillDone  out  1  one-cycle pulse in DONE
- XWrite  out  9  memory write column
- YWrite  out  8  memory write row
- WriteValue  out  ColorBits  memory write data
- WriteEnable  out  1  memory write strobe; the Memory instance writes only when high

## Operation
- **FSM states:** IDLE, FILL, DONE.
- **IDLE:**
  - On FillStart, latch the bounds and colour.
  - Clamp FillX1 to Width-1 and FillY1 to Height-1.
  - If X0 > X1 or Y0 > Y1 after clamping → DONE with no writes; otherwise → FILL, with the walker at (X0, Y0).
- **FILL:**
  - Each cycle without a core write, issue one pixel at the walker position, then advance in raster order (x fastest). At x = X1, wrap x to X0 and increment y.
  - Issuing (X1, Y1) → DONE.
- **DONE:** FillDone = 1 for one cycle, then → IDLE unconditionally.
- **Ignored FillStart:** FillStart is ignored in FILL and DONE. There is no queueing.
- **Core writes:**
  - Accepted every cycle that PxValid && PxReady.
  - The coordinate is out of range if PxX ≥ Width or PxY ≥ Height. An out-of-range request is still accepted but is dropped (WriteEnable stays 0), and it does not stall the fill.
- **Arbitration per cycle:**
  - An in-range core write wins, and the fill does not advance that cycle.
  - Otherwise the fill pixel, if in FILL.
  - Otherwise WriteEnable = 0.
- **Width rules:** coordinate compares are unsigned at 9/8 bits. The walker counters match the port widths, so no overflow is possible given the clamp.

## Timing
- **Reset:** rst high at a clock edge →
  - state = IDLE;
  - XWrite = 0, YWrite = 0, WriteValue = 0, WriteEnable = 0;
  - FillBusy = 0, FillDone = 0, PxReady = 0.
- **Reset mid-fill:** aborts the fill. No further writes occur and FillDone is not pulsed.
- **Write latency:** one cycle. A request selected in cycle k appears on XWrite/YWrite/WriteValue/WriteEnable in cycle k+1.
- **Uncontended N-pixel fill, FillStart sampled in cycle 0:**
  - FILL in cycles 1..N;
  - writes on the port in cycles 2..N+1;
  - DONE/FillDone in cycle N+1, aligned with the last write;
  - FillBusy high in cycles 1..N+1.
- **Contended fill:** each accepted in-range core write during FILL delays the remainder by exactly one cycle.
- **Empty rectangle:** DONE in cycle 1, with no writes.

## Structure
- **Package `fb_pkg`:**
  - XBits = 9, YBits = 8;
  - the fill-state enum {IDLE, FILL, DONE};
  - a packed struct for a write beat {x, y, value, enable}.
- **Sub-module `fb_rect_walker`:**
  - holds the x/y counter pair with load(X0, Y0), advance, and bounds;
  - outputs the current coordinate and a `last` flag for (X1, Y1).
- **Top level:** the FSM, arbitration mux, clamp logic, and output register.

## Test plan
Run with Width = 5, Height = 10, ColorBits = 3.

1. **Reset mid-fill:** assert rst for 2 cycles during an active fill → all outputs 0, no WriteEnable afterwards, FillBusy = 0, no FillDone.
2. **Single core write:** PxValid with (2, 4, 3'b010) in cycle 0 → cycle 1: WriteEnable = 1, XWrite = 2, YWrite = 4, WriteValue = 3'b010.
3. **Basic fill:** rectangle (1,2)-(2,3), colour 3'b101, FillStart in cycle 0 → writes (1,2), (2,2), (1,3), (2,3) in cycles 2–5; FillDone in cycle 5 only; FillBusy in cycles 1–5.
4. **Contended fill:** scenario 3 plus a core write (4, 9, 3'b111) in cycle 2 → cycle 3 shows (4,9,111); (2,2) moves to cycle 4; last write and FillDone in cycle 6.
5. **Clamp and empty fill:**
   - Fill (3,8)-(7,12) → clamps to x 3..4, y 8..9: exactly 4 writes, FillDone in cycle 5.
   - Fill (4,0)-(1,0) → zero writes, FillDone in cycle 1.
6. **Drop and ignore:**
   - Core write (5, 0) → accepted, no WriteEnable, fill unaffected.
   - FillStart asserted during FILL → ignored; the first fill's pixel count is unchanged.

Source files
------------

// File: rtl/fb_write_scheduler_pkg.sv
// Shared widths and types for the frame-buffer write-port scheduler.
package fb_pkg;

   localparam int XBits     = 9;
   localparam int YBits     = 8;
   localparam int ValueBits = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_t;

   // value is sized for the widest supported pixel; the top uses the low COLOR_BITS
   typedef struct packed {
      logic [XBits-1:0]     x;
      logic [YBits-1:0]     y;
      logic [ValueBits-1:0] value;
      logic                 enable;
   } write_beat_t;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Core pixel port, fill command port and memory write port of the scheduler.
interface fb_write_scheduler_if
   import fb_pkg::*;
#(
   parameter int COLOR_BITS = 3
) ();

   logic                  px_valid;
   logic                  px_ready;
   logic [XBits-1:0]      px_x;
   logic [YBits-1:0]      px_y;
   logic [COLOR_BITS-1:0] px_color;

   logic                  fill_start;
   logic [XBits-1:0]      fill_x0;
   logic [XBits-1:0]      fill_x1;
   logic [YBits-1:0]      fill_y0;
   logic [YBits-1:0]      fill_y1;
   logic [COLOR_BITS-1:0] fill_color;
   logic                  fill_busy;
   logic                  fill_done;

   logic [XBits-1:0]      x_write;
   logic [YBits-1:0]      y_write;
   logic [COLOR_BITS-1:0] write_value;
   logic                  write_enable;

   modport master (
      output px_valid, px_x, px_y, px_color,
      output fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
      input  px_ready, fill_busy, fill_done,
      input  x_write, y_write, write_value, write_enable
   );

   modport slave (
      input  px_valid, px_x, px_y, px_color,
      input  fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
      output px_ready, fill_busy, fill_done,
      output x_write, y_write, write_value, write_enable
   );

endinterface

// File: rtl/fb_rect_walker.sv
// Raster walker over an inclusive rectangle: x runs fastest, wrapping to x0 and bumping y.
module fb_rect_walker
   import fb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             advance,
   input  logic [XBits-1:0] x0,
   input  logic [XBits-1:0] x1,
   input  logic [YBits-1:0] y0,
   input  logic [YBits-1:0] y1,
   output logic [XBits-1:0] x,
   output logic [YBits-1:0] y,
   output logic             last
);

   logic [XBits-1:0] x0_q;
   logic [XBits-1:0] x1_q;
   logic [YBits-1:0] y1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         x    <= '0;
         y    <= '0;
         x0_q <= '0;
         x1_q <= '0;
         y1_q <= '0;
      end else if (load) begin
         x    <= x0;
         y    <= y0;
         x0_q <= x0;
         x1_q <= x1;
         y1_q <= y1;
      end else if (advance) begin
         if (x == x1_q) begin
            x <= x0_q;
            y <= y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   assign last = (x == x1_q) && (y == y1_q);

endmodule

// File: rtl/fb_write_scheduler.sv
// Owns the frame-buffer write port: in-range core pixel writes take priority,
// otherwise the rectangle-fill sequencer issues one pixel per cycle.
//
// state | meaning
// IDLE  | no fill in progress; fill_start latches and clamps a new rectangle
// FILL  | walker issues one pixel on each cycle the core does not write
// DONE  | one-cycle fill_done pulse, then back to IDLE
module fb_write_scheduler
   import fb_pkg::*;
#(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 240,
   parameter int COLOR_BITS = 3
) (
   input logic                 clk,
   input logic                 rst,
   fb_write_scheduler_if.slave bus
);

   localparam logic [XBits:0]   X_LIMIT = WIDTH[XBits:0];
   localparam logic [YBits:0]   Y_LIMIT = HEIGHT[YBits:0];
   localparam int               X_MAX_I = WIDTH - 1;
   localparam int               Y_MAX_I = HEIGHT - 1;
   localparam logic [XBits-1:0] X_MAX   = X_MAX_I[XBits-1:0];
   localparam logic [YBits-1:0] Y_MAX   = Y_MAX_I[YBits-1:0];

   fill_state_t           state;
   write_beat_t           beat_d;
   write_beat_t           beat_q;
   logic [COLOR_BITS-1:0] color_q;
   logic                  fill_busy_q;
   logic                  fill_done_q;

   logic [XBits-1:0]      x1_clamp;
   logic [YBits-1:0]      y1_clamp;
   logic [XBits-1:0]      walk_x;
   logic [YBits-1:0]      walk_y;
   logic                  walk_last;
   logic                  rect_empty;
   logic                  start_load;
   logic                  core_hit;
   logic                  fill_go;
   logic                  unused_value_bits;

   assign bus.px_ready = !rst;

   // out-of-range core writes are accepted but neither written nor allowed to stall the fill
   assign core_hit = bus.px_valid && bus.px_ready
                     && ({1'b0, bus.px_x} < X_LIMIT)
                     && ({1'b0, bus.px_y} < Y_LIMIT);

   assign x1_clamp   = (bus.fill_x1 > X_MAX) ? X_MAX : bus.fill_x1;
   assign y1_clamp   = (bus.fill_y1 > Y_MAX) ? Y_MAX : bus.fill_y1;
   assign rect_empty = (bus.fill_x0 > x1_clamp) || (bus.fill_y0 > y1_clamp);
   assign start_load = (state == IDLE) && bus.fill_start;
   assign fill_go    = (state == FILL) && !core_hit;

   fb_rect_walker u_walker (
      .clk     (clk),
      .rst     (rst),
      .load    (start_load),
      .advance (fill_go),
      .x0      (bus.fill_x0),
      .x1      (x1_clamp),
      .y0      (bus.fill_y0),
      .y1      (y1_clamp),
      .x       (walk_x),
      .y       (walk_y),
      .last    (walk_last)
   );

   always_comb begin
      beat_d = '0;
      if (core_hit) begin
         beat_d.x      = bus.px_x;
         beat_d.y      = bus.px_y;
         beat_d.value  = ValueBits'(bus.px_color);
         beat_d.enable = 1'b1;
      end else if (fill_go) begin
         beat_d.x      = walk_x;
         beat_d.y      = walk_y;
         beat_d.value  = ValueBits'(color_q);
         beat_d.enable = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         beat_q      <= '0;
         color_q     <= '0;
         fill_busy_q <= 1'b0;
         fill_done_q <= 1'b0;
      end else begin
         beat_q      <= beat_d;
         fill_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.fill_start) begin
                  color_q     <= bus.fill_color;
                  fill_busy_q <= 1'b1;
                  if (rect_empty) begin
                     state       <= DONE;
                     fill_done_q <= 1'b1;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            FILL: begin
               if (fill_go && walk_last) begin
                  state       <= DONE;
                  fill_done_q <= 1'b1;
               end
            end
            DONE: begin
               state       <= IDLE;
               fill_busy_q <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               fill_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.x_write      = beat_q.x;
   assign bus.y_write      = beat_q.y;
   assign bus.write_value  = beat_q.value[COLOR_BITS-1:0];
   assign bus.write_enable = beat_q.enable;
   assign bus.fill_busy    = fill_busy_q;
   assign bus.fill_done    = fill_done_q;

   assign unused_value_bits = ^beat_q.value;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler with a pixel-queue reference model and literal scenario checks.
module tb_fb_write_scheduler;
   import fb_pkg::*;

   localparam int W  = 5;
   localparam int H  = 10;
   localparam int CB = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fb_write_scheduler_if #(.COLOR_BITS(CB)) bus ();

   fb_write_scheduler #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: a fill becomes a queue of pixels; each cycle pops one unless the core writes
   typedef enum {M_IDLE, M_FILL, M_DONE} mmode_t;
   mmode_t mode = M_IDLE;
   int     pix_x[$];
   int     pix_y[$];
   int     fill_v = 0;
   int     e_we = 0, e_x = 0, e_y = 0, e_v = 0, e_busy = 0, e_done = 0;
   bit     model_on = 1'b0;
   int     cyc = 0;

   always @(posedge clk) begin : model
      mmode_t old;
      int     xe;
      int     ye;
      cyc++;
      if (rst) begin
         mode = M_IDLE;
         pix_x.delete();
         pix_y.delete();
         e_we = 0; e_x = 0; e_y = 0; e_v = 0; e_busy = 0; e_done = 0;
         model_on = 1'b1;
      end else begin
         old  = mode;
         e_we = 0;
         if (bus.px_valid && int'(bus.px_x) < W && int'(bus.px_y) < H) begin
            e_we = 1; e_x = int'(bus.px_x); e_y = int'(bus.px_y); e_v = int'(bus.px_color);
         end else if (old == M_FILL) begin
            e_we = 1; e_x = pix_x.pop_front(); e_y = pix_y.pop_front(); e_v = fill_v;
            if (pix_x.size() == 0) mode = M_DONE;
         end
         if (old == M_IDLE && bus.fill_start) begin
            xe = (int'(bus.fill_x1) > W - 1) ? W - 1 : int'(bus.fill_x1);
            ye = (int'(bus.fill_y1) > H - 1) ? H - 1 : int'(bus.fill_y1);
            for (int yy = int'(bus.fill_y0); yy <= ye; yy++)
               for (int xx = int'(bus.fill_x0); xx <= xe; xx++) begin
                  pix_x.push_back(xx);
                  pix_y.push_back(yy);
               end
            fill_v = int'(bus.fill_color);
            mode   = (pix_x.size() == 0) ? M_DONE : M_FILL;
         end else if (old == M_DONE) begin
            mode = M_IDLE;
         end
         e_busy = (mode != M_IDLE) ? 1 : 0;
         e_done = (mode == M_DONE) ? 1 : 0;
      end
   end

   // per-scenario log of observed outputs, indexed relative to the stimulus cycle
   int base = 0;
   int wr_rel[$], wr_x[$], wr_y[$], wr_v[$];
   int done_rel[$];
   int busy_cnt = 0;
   int busy_first = -1;

   always @(negedge clk) begin
      if (model_on) begin
         check("px_ready", int'(bus.px_ready), int'(!rst));
         check("write_enable", int'(bus.write_enable), e_we);
         if (e_we != 0) begin
            check("x_write", int'(bus.x_write), e_x);
            check("y_write", int'(bus.y_write), e_y);
            check("write_value", int'(bus.write_value), e_v);
         end
         check("fill_busy", int'(bus.fill_busy), e_busy);
         check("fill_done", int'(bus.fill_done), e_done);
      end
      if (bus.write_enable) begin
         wr_rel.push_back(cyc - base);
         wr_x.push_back(int'(bus.x_write));
         wr_y.push_back(int'(bus.y_write));
         wr_v.push_back(int'(bus.write_value));
      end
      if (bus.fill_done) done_rel.push_back(cyc - base);
      if (bus.fill_busy) begin
         if (busy_first < 0) busy_first = cyc - base;
         busy_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_log();
      base = cyc;
      wr_rel.delete(); wr_x.delete(); wr_y.delete(); wr_v.delete();
      done_rel.delete();
      busy_cnt   = 0;
      busy_first = -1;
   endtask

   task automatic set_fill(input int x0, input int x1, input int y0, input int y1, input int c);
      bus.fill_start = 1'b1;
      bus.fill_x0    = 9'(x0);
      bus.fill_x1    = 9'(x1);
      bus.fill_y0    = 8'(y0);
      bus.fill_y1    = 8'(y1);
      bus.fill_color = 3'(c);
   endtask

   task automatic set_px(input bit v, input int x, input int y, input int c);
      bus.px_valid = v;
      bus.px_x     = 9'(x);
      bus.px_y     = 8'(y);
      bus.px_color = 3'(c);
   endtask

   task automatic expect_wr(input string name, input int i, input int rel, input int x, input int y, input int v);
      if (i < wr_rel.size()) begin
         check({name, "_cycle"}, wr_rel[i], rel);
         check({name, "_x"}, wr_x[i], x);
         check({name, "_y"}, wr_y[i], y);
         check({name, "_value"}, wr_v[i], v);
      end else begin
         check({name, "_present"}, 0, 1);
      end
   endtask

   task automatic expect_done(input string name, input int rel);
      check({name, "_done_count"}, done_rel.size(), 1);
      if (done_rel.size() > 0) check({name, "_done_cycle"}, done_rel[0], rel);
   endtask

   initial begin
      set_px(1'b0, 0, 0, 0);
      set_fill(0, 0, 0, 0, 0);
      bus.fill_start = 1'b0;

      // reset state
      tick(); tick();
      check("reset_write_enable", int'(bus.write_enable), 0);
      check("reset_xyv", int'(bus.x_write) + int'(bus.y_write) + int'(bus.write_value), 0);
      check("reset_busy_done", int'(bus.fill_busy) + int'(bus.fill_done), 0);
      check("reset_px_ready", int'(bus.px_ready), 0);
      rst = 1'b0;
      repeat (2) tick();

      // single core write
      start_log();
      set_px(1'b1, 2, 4, 3'b010);
      tick();
      set_px(1'b0, 0, 0, 0);
      repeat (3) tick();
      check("core_count", wr_rel.size(), 1);
      expect_wr("core", 0, 1, 2, 4, 2);
      check("core_no_done", done_rel.size(), 0);

      // basic fill
      start_log();
      set_fill(1, 2, 2, 3, 3'b101);
      tick();
      bus.fill_start = 1'b0;
      repeat (7) tick();
      check("basic_count", wr_rel.size(), 4);
      expect_wr("basic0", 0, 2, 1, 2, 5);
      expect_wr("basic1", 1, 3, 2, 2, 5);
      expect_wr("basic2", 2, 4, 1, 3, 5);
      expect_wr("basic3", 3, 5, 2, 3, 5);
      expect_done("basic", 5);
      check("basic_busy_cycles", busy_cnt, 5);
      check("basic_busy_first", busy_first, 1);

      // contended fill
      start_log();
      set_fill(1, 2, 2, 3, 3'b101);
      tick();
      bus.fill_start = 1'b0;
      tick();
      set_px(1'b1, 4, 9, 3'b111);
      tick();
      set_px(1'b0, 0, 0, 0);
      repeat (6) tick();
      check("cont_count", wr_rel.size(), 5);
      expect_wr("cont0", 0, 2, 1, 2, 5);
      expect_wr("cont1", 1, 3, 4, 9, 7);
      expect_wr("cont2", 2, 4, 2, 2, 5);
      expect_wr("cont4", 4, 6, 2, 3, 5);
      expect_done("cont", 6);

      // clamped fill
      start_log();
      set_fill(3, 7, 8, 12, 3'b110);
      tick();
      bus.fill_start = 1'b0;
      repeat (7) tick();
      check("clamp_count", wr_rel.size(), 4);
      expect_wr("clamp0", 0, 2, 3, 8, 6);
      expect_wr("clamp1", 1, 3, 4, 8, 6);
      expect_wr("clamp3", 3, 5, 4, 9, 6);
      expect_done("clamp", 5);

      // empty fill
      start_log();
      set_fill(4, 1, 0, 0, 3'b011);
      tick();
      bus.fill_start = 1'b0;
      repeat (4) tick();
      check("empty_count", wr_rel.size(), 0);
      expect_done("empty", 1);
      check("empty_busy_cycles", busy_cnt, 1);

      // out-of-range core write does not stall the fill
      start_log();
      set_fill(0, 1, 0, 0, 3'b100);
      tick();
      bus.fill_start = 1'b0;
      set_px(1'b1, 5, 0, 3'b111);
      tick();
      set_px(1'b0, 0, 0, 0);
      repeat (5) tick();
      check("drop_count", wr_rel.size(), 2);
      expect_wr("drop0", 0, 2, 0, 0, 4);
      expect_wr("drop1", 1, 3, 1, 0, 4);
      expect_done("drop", 3);

      // fill_start during FILL is ignored
      start_log();
      set_fill(0, 2, 0, 1, 3'b010);
      tick();
      bus.fill_start = 1'b0;
      tick();
      set_fill(0, 4, 0, 9, 3'b111);
      repeat (5) tick();
      bus.fill_start = 1'b0;
      repeat (5) tick();
      check("ignore_count", wr_rel.size(), 6);
      expect_wr("ignore5", 5, 7, 2, 1, 2);
      expect_done("ignore", 7);

      // reset in the middle of a fill
      start_log();
      set_fill(0, 4, 0, 9, 3'b001);
      tick();
      bus.fill_start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      check("midrst_write_enable", int'(bus.write_enable), 0);
      check("midrst_xyv", int'(bus.x_write) + int'(bus.y_write) + int'(bus.write_value), 0);
      check("midrst_busy", int'(bus.fill_busy), 0);
      tick();
      rst = 1'b0;
      repeat (10) tick();
      check("midrst_count", wr_rel.size(), 4);
      if (wr_rel.size() > 0) check("midrst_last_cycle", wr_rel[wr_rel.size()-1], 5);
      check("midrst_no_done", done_rel.size(), 0);
      check("midrst_busy_cycles", busy_cnt, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
